// File: rtl/mult_shift_add_n.sv
// mult_shift_add_n: sequential shift-and-add unsigned multiplier, one
// multiplier bit per clock. Start/Done handshake with a Busy status.
// Optional build macro MULT_EARLY_EXIT_EN: finish as soon as the remaining
// multiplier bits are all zero (result identical to the full run).
module mult_shift_add_n #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               St,
  input  logic [WIDTH-1:0]   Mplier,
  input  logic [WIDTH-1:0]   Mcand,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH:0]   ACC
);

  localparam int CNT_W = $clog2(WIDTH+1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [WIDTH-1:0]   mcand_r, mcand_nxt;
  logic [2*WIDTH:0]   acc_nxt;
  logic [WIDTH:0]     sum;

`ifdef MULT_EARLY_EXIT_EN
  // Mask of the multiplier bits not yet consumed (low cnt bits of ACC).
  // With cnt==WIDTH the shift wraps to zero and the mask becomes all ones.
  logic [WIDTH-1:0]   rem_mask;
  logic               rem_zero;
  always_comb begin
    rem_mask = ({{(WIDTH-1){1'b0}}, 1'b1} << cnt) - {{(WIDTH-1){1'b0}}, 1'b1};
    rem_zero = ~|(ACC[WIDTH-1:0] & rem_mask);
  end
`endif

  // Upper half plus multiplicand when the current multiplier bit is set.
  always_comb begin
    sum = ACC[2*WIDTH:WIDTH] + (ACC[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
  end

  // Next-state and datapath update; defaults hold everything.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mcand_nxt = mcand_r;
    acc_nxt   = ACC;
    unique case (state)
      IDLE: begin
        if (St) begin
          acc_nxt   = {{(WIDTH+1){1'b0}}, Mplier};
          mcand_nxt = Mcand;
          cnt_nxt   = CNT_W'(WIDTH);
          state_nxt = CALC;
        end
      end
      CALC: begin
`ifdef MULT_EARLY_EXIT_EN
        if (rem_zero) begin
          // Nothing left to add: align the product in one shift.
          acc_nxt   = ACC >> cnt;
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          acc_nxt = {1'b0, sum, ACC[WIDTH-1:1]};
          cnt_nxt = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = DONE;
        end
`else
        acc_nxt = {1'b0, sum, ACC[WIDTH-1:1]};
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = DONE;
`endif
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      mcand_r <= '0;
      ACC     <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mcand_r <= mcand_nxt;
      ACC     <= acc_nxt;
      Busy    <= (state_nxt == CALC);
      Done    <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_mult_shift_add_n.sv
// Bench for mult_shift_add_n: WIDTH=4 and WIDTH=8 instances, directed steps
// plus random operands checked against plain arithmetic.
module tb_mult_shift_add_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st4 = 1'b0, st8 = 1'b0;
  logic [3:0]  mp4 = '0, mc4 = '0;
  logic [7:0]  mp8 = '0, mc8 = '0;
  logic        busy4, done4, busy8, done8;
  logic [8:0]  acc4;
  logic [16:0] acc8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult_shift_add_n #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .St(st4), .Mplier(mp4), .Mcand(mc4),
    .Busy(busy4), .Done(done4), .ACC(acc4));

  mult_shift_add_n #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .St(st8), .Mplier(mp8), .Mcand(mc8),
    .Busy(busy8), .Done(done8), .ACC(acc8));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w8, input bit s, input logic [7:0] mp, input logic [7:0] mc);
    if (w8) begin st8 = s; mp8 = mp; mc8 = mc; end
    else    begin st4 = s; mp4 = mp[3:0]; mc4 = mc[3:0]; end
  endtask

  function automatic logic cur_busy(input bit w8);
    return w8 ? busy8 : busy4;
  endfunction
  function automatic logic cur_done(input bit w8);
    return w8 ? done8 : done4;
  endfunction
  function automatic logic [16:0] cur_acc(input bit w8);
    return w8 ? acc8 : {8'b0, acc4};
  endfunction

  // Expected number of CALC cycles from the multiplier value alone.
  function automatic int exp_busy(input int w, input int mp);
`ifdef MULT_EARLY_EXIT_EN
    int k;
    if (mp == 0) return 1;
    k = 0;
    for (int i = 0; i < w; i++) if (mp[i]) k = i;
    return (k + 2 < w) ? k + 2 : w;
`else
    return w;
`endif
  endfunction

  // One full operation: pulse St, scramble operands, wait for Done.
  task automatic run(input bit w8, input logic [7:0] mp_in, input logic [7:0] mc_in, input string tag);
    int w, n, guard, mp, mc;
    logic [16:0] hold;
    w  = w8 ? 8 : 4;
    mp = w8 ? int'(mp_in) : int'(mp_in[3:0]);
    mc = w8 ? int'(mc_in) : int'(mc_in[3:0]);
    drive(w8, 1'b1, mp_in, mc_in);
    tick;
    drive(w8, 1'b0, 8'($urandom), 8'($urandom));
    n = 0; guard = 0;
    while (!cur_done(w8) && guard < 40) begin
      if (cur_busy(w8)) n++;
      tick;
      guard++;
    end
    chk({tag, "_done"}, 32'(cur_done(w8)), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy(w, mp)));
    chk({tag, "_acc"}, 32'(cur_acc(w8)), 32'(mp * mc));
    chk({tag, "_busy_at_done"}, 32'(cur_busy(w8)), 32'd0);
    hold = cur_acc(w8);
    tick;
    chk({tag, "_done_pulse"}, 32'(cur_done(w8)), 32'd0);
    chk({tag, "_hold"}, 32'(cur_acc(w8)), 32'(hold));
  endtask

  initial begin
    int t, t1, t2, g;
    logic [16:0] a1, a2;

    // Reset state
    #2;
    chk("rst_acc4", 32'(acc4), 32'd0);
    chk("rst_busy4", 32'(busy4), 32'd0);
    chk("rst_done4", 32'(done4), 32'd0);
    chk("rst_acc8", 32'(acc8), 32'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // Small and full-scale WIDTH=4 products
    run(1'b0, 8'd2, 8'd2, "w4_2x2");
    chk("w4_2x2_const", 32'(acc4), 32'd4);
    run(1'b0, 8'd15, 8'd15, "w4_15x15");
    chk("w4_15x15_const", 32'(acc4), 32'h0E1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("w4_idle_hold", 32'(acc4), 32'd225);
      chk("w4_idle_busy", 32'(busy4), 32'd0);
    end

    // St held high, operands changed mid-operation
    drive(1'b0, 1'b1, 8'd3, 8'd5);
    tick;
    drive(1'b0, 1'b1, 8'd7, 8'd6);
    t = 0; t1 = -1; t2 = -1; a1 = '0; a2 = '0; g = 0;
    while (t2 < 0 && g < 60) begin
      if (done4) begin
        if (t1 < 0) begin t1 = t; a1 = {8'b0, acc4}; end
        else begin t2 = t; a2 = {8'b0, acc4}; end
      end
      tick; t++; g++;
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    chk("held_first_acc", 32'(a1), 32'd15);
    chk("held_second_acc", 32'(a2), 32'd42);
    chk("held_spacing", 32'(t2 - t1), 32'(exp_busy(4, 7) + 2));
    repeat (12) tick;

    // Asynchronous reset two cycles into CALC
    drive(1'b0, 1'b1, 8'd9, 8'd11);
    tick;
    drive(1'b0, 1'b0, 8'd0, 8'd0);
    tick; tick;
    chk("pre_rst_busy", 32'(busy4), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_acc", 32'(acc4), 32'd0);
    chk("async_rst_busy", 32'(busy4), 32'd0);
    chk("async_rst_done", 32'(done4), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("post_rst_idle_busy", 32'(busy4), 32'd0);
      chk("post_rst_idle_acc", 32'(acc4), 32'd0);
    end

    // WIDTH=8 boundaries
    run(1'b1, 8'd255, 8'd255, "w8_255x255");
    chk("w8_255x255_const", 32'(acc8), 32'd65025);
    run(1'b1, 8'h00, 8'hA5, "w8_0xA5");
    run(1'b1, 8'hA5, 8'h00, "w8_A5x0");
    run(1'b1, 8'd3, 8'd200, "w8_3x200");
    chk("w8_3x200_const", 32'(acc8), 32'd600);
    run(1'b1, 8'h80, 8'hFF, "w8_msb");
    run(1'b1, 8'h01, 8'hFF, "w8_lsb");

    // Random operands; sparse multipliers exercise the early-exit path
    for (int i = 0; i < 20; i++) begin
      run(1'b0, 8'($urandom), 8'($urandom), "w4_rand");
      run(1'b1, 8'($urandom) >> $urandom_range(0, 7), 8'($urandom), "w8_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
